// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank with one write port and two
// asynchronous read ports.
//
// Parameters:
//   WIDTH    - data width of every register (>= 2)
//   DEPTH    - number of registers (power of two, >= 2)
//   ZERO_REG - 1: register 0 reads as zero and ignores writes
//   BYPASS   - 1: a same-cycle write is forwarded to a matching read port
//
// Ports:
//   clk_i      - clock; state changes on its rising edge
//   rst_n_i    - asynchronous active-low reset, clears every register
//   wen_i      - write enable
//   wop_i      - write op: 00 LOAD, 01 INC, 10 DEC, 11 CLR
//   waddr_i    - write target register
//   wdata_i    - LOAD data (ignored by the other ops)
//   raddr_a_i  - read port A address
//   raddr_b_i  - read port B address
//   rdata_a_o  - read port A data
//   rdata_b_o  - read port B data
//   wval_o     - value being written this cycle, 0 when nothing is written
module reg_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wen_i,
  input  logic [1:0]        wop_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  output logic [WIDTH-1:0]  rdata_b_o,
  output logic [WIDTH-1:0]  wval_o
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] wval;
  logic             wr_blocked;
  logic             wr_active;

  // Write path: next value of the addressed register.
  always_comb begin
    cur_val = regs_q[waddr_i];
    case (wop_i)
      OP_LOAD: next_val = wdata_i;
      OP_INC:  next_val = cur_val + WIDTH'(1);
      OP_DEC:  next_val = cur_val - WIDTH'(1);
      default: next_val = '0;
    endcase

    // Register 0 writes are dropped when it is hardwired to zero.
    wr_blocked = (ZERO_REG != 0) && (waddr_i == '0);
    // While reset is held nothing is written, so nothing is reported or
    // forwarded either; this keeps the read ports at zero during reset.
    wr_active  = rst_n_i && wen_i && !wr_blocked;
    wval       = wr_active ? next_val : '0;

    regs_d = regs_q;
    if (wr_active) begin
      regs_d[waddr_i] = next_val;
    end
  end

  // Register 0 is never written when ZERO_REG=1, so it stays at its reset
  // value and synthesis can fold it to a constant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: stored value, optionally overridden by the in-flight write,
  // with the zero register taking priority over both.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    if ((BYPASS != 0) && wr_active && (raddr_a_i == waddr_i)) begin
      rdata_a_o = wval;
    end
    if ((ZERO_REG != 0) && (raddr_a_i == '0)) begin
      rdata_a_o = '0;
    end

    rdata_b_o = regs_q[raddr_b_i];
    if ((BYPASS != 0) && wr_active && (raddr_b_i == waddr_i)) begin
      rdata_b_o = wval;
    end
    if ((ZERO_REG != 0) && (raddr_b_i == '0)) begin
      rdata_b_o = '0;
    end
  end

  assign wval_o = wval;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: four instances with different parameter sets share one
// set of stimulus signals. Instance 0: 8x4 bypass; 1: 8x4 no bypass;
// 2: 8x4 zero register with bypass; 3: 16x8 bypass.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [1:0]  wop;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  ra;
  logic [2:0]  rb;

  logic [7:0]  a0, b0, w0, a1, b1, w1, a2, b2, w2;
  logic [15:0] a3, b3, w3;
  logic [15:0] got_a [4];
  logic [15:0] got_b [4];
  logic [15:0] got_w [4];

  int checks = 0;
  int errors = 0;
  int unsigned mem [4][8];

  always #5 clk = ~clk;

  reg_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .wen_i(wen), .wop_i(wop), .waddr_i(waddr[1:0]),
    .wdata_i(wdata[7:0]), .raddr_a_i(ra[1:0]), .raddr_b_i(rb[1:0]),
    .rdata_a_o(a0), .rdata_b_o(b0), .wval_o(w0));

  reg_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk_i(clk), .rst_n_i(rst_n), .wen_i(wen), .wop_i(wop), .waddr_i(waddr[1:0]),
    .wdata_i(wdata[7:0]), .raddr_a_i(ra[1:0]), .raddr_b_i(rb[1:0]),
    .rdata_a_o(a1), .rdata_b_o(b1), .wval_o(w1));

  reg_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1), .BYPASS(1)) u_zr (
    .clk_i(clk), .rst_n_i(rst_n), .wen_i(wen), .wop_i(wop), .waddr_i(waddr[1:0]),
    .wdata_i(wdata[7:0]), .raddr_a_i(ra[1:0]), .raddr_b_i(rb[1:0]),
    .rdata_a_o(a2), .rdata_b_o(b2), .wval_o(w2));

  reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_w16 (
    .clk_i(clk), .rst_n_i(rst_n), .wen_i(wen), .wop_i(wop), .waddr_i(waddr),
    .wdata_i(wdata), .raddr_a_i(ra), .raddr_b_i(rb),
    .rdata_a_o(a3), .rdata_b_o(b3), .wval_o(w3));

  always_comb begin
    got_a[0] = {8'h00, a0}; got_b[0] = {8'h00, b0}; got_w[0] = {8'h00, w0};
    got_a[1] = {8'h00, a1}; got_b[1] = {8'h00, b1}; got_w[1] = {8'h00, w1};
    got_a[2] = {8'h00, a2}; got_b[2] = {8'h00, b2}; got_w[2] = {8'h00, w2};
    got_a[3] = a3;          got_b[3] = b3;          got_w[3] = w3;
  end

  // ---------------- reference model ----------------
  function automatic int cfg_w(int k); return (k == 3) ? 16 : 8; endfunction
  function automatic int cfg_d(int k); return (k == 3) ? 8 : 4;  endfunction
  function automatic bit cfg_z(int k); return (k == 2);          endfunction
  function automatic bit cfg_b(int k); return (k != 1);          endfunction

  // Value the write port stores this cycle (0 when nothing is stored).
  function automatic int unsigned m_wval(int k);
    int unsigned mask = (32'd1 << cfg_w(k)) - 32'd1;
    int a = int'(waddr) % cfg_d(k);
    int unsigned cur = mem[k][a];
    if (!rst_n || !wen) return 0;
    if (cfg_z(k) && a == 0) return 0;
    case (wop)
      2'd0:    return int'(wdata) & mask;
      2'd1:    return (cur + 1) & mask;
      2'd2:    return (cur + mask) & mask;   // minus one, modulo 2^W
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned m_read(int k, logic [2:0] addr);
    int a = int'(addr) % cfg_d(k);
    if (cfg_z(k) && a == 0) return 0;
    if (!rst_n) return 0;
    if (cfg_b(k) && wen && a == int'(waddr) % cfg_d(k) && !(cfg_z(k) && a == 0))
      return m_wval(k);
    return mem[k][a];
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) for (int j = 0; j < 8; j++) mem[k][j] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s i%0d rdata_a", tag, k), got_a[k], 16'(m_read(k, ra)));
      chk($sformatf("%s i%0d rdata_b", tag, k), got_b[k], 16'(m_read(k, rb)));
      chk($sformatf("%s i%0d wval", tag, k), got_w[k], 16'(m_wval(k)));
    end
  endtask

  // Capture model next-state from pre-edge inputs, then commit at the edge.
  task automatic commit();
    int unsigned nv [4];
    bit          we [4];
    int          ad [4];
    for (int k = 0; k < 4; k++) begin
      ad[k] = int'(waddr) % cfg_d(k);
      nv[k] = m_wval(k);
      we[k] = rst_n && wen && !(cfg_z(k) && ad[k] == 0);
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) if (we[k] && rst_n) mem[k][ad[k]] = nv[k];
  endtask

  task automatic apply(logic r, logic w, logic [1:0] op, logic [2:0] wa,
                       logic [15:0] wd, logic [2:0] xa, logic [2:0] xb);
    @(negedge clk);
    rst_n = r; wen = w; wop = op; waddr = wa; wdata = wd; ra = xa; rb = xb;
    #1;
  endtask

  task automatic step(string tag, logic r, logic w, logic [1:0] op, logic [2:0] wa,
                      logic [15:0] wd, logic [2:0] xa, logic [2:0] xb);
    apply(r, w, op, wa, wd, xa, xb);
    $display("txn %s rst_n=%0b wen=%0b op=%0d wa=%0d wd=%h ra=%0d rb=%0d",
             tag, r, w, op, wa, wd, xa, xb);
    check_all(tag);
    commit();
  endtask

  // ---------------- directed vector table (instance 0) ----------------
  typedef struct packed {
    logic        rst_n;
    logic        wen;
    logic [1:0]  op;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  ew;
  } vec_t;

  vec_t vec [14];

  initial begin
    rst_n = 1'b0; wen = 1'b0; wop = 2'd0; waddr = 3'd0; wdata = 16'h0; ra = 3'd0; rb = 3'd0;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 8; j++) mem[k][j] = 0;

    //                rst wen op  wa    wd         ra  rb   ea     eb     ew
    vec[0]  = '{1'b0, 1'b1, 2'd0, 3'd1, 16'h00CC, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00};
    vec[1]  = '{1'b1, 1'b1, 2'd0, 3'd1, 16'h00CC, 3'd1, 3'd2, 8'hCC, 8'h00, 8'hCC};
    vec[2]  = '{1'b1, 1'b0, 2'd0, 3'd1, 16'h00FF, 3'd1, 3'd2, 8'hCC, 8'h00, 8'h00};
    vec[3]  = '{1'b1, 1'b0, 2'd0, 3'd1, 16'h00FF, 3'd1, 3'd2, 8'hCC, 8'h00, 8'h00};
    vec[4]  = '{1'b1, 1'b1, 2'd0, 3'd2, 16'h00FF, 3'd2, 3'd1, 8'hFF, 8'hCC, 8'hFF};
    vec[5]  = '{1'b1, 1'b1, 2'd1, 3'd2, 16'h0000, 3'd2, 3'd3, 8'h00, 8'h00, 8'h00};
    vec[6]  = '{1'b1, 1'b1, 2'd2, 3'd3, 16'h0000, 3'd3, 3'd2, 8'hFF, 8'h00, 8'hFF};
    vec[7]  = '{1'b1, 1'b0, 2'd3, 3'd3, 16'h0000, 3'd3, 3'd1, 8'hFF, 8'hCC, 8'h00};
    vec[8]  = '{1'b1, 1'b1, 2'd0, 3'd2, 16'h005A, 3'd2, 3'd2, 8'h5A, 8'h5A, 8'h5A};
    vec[9]  = '{1'b1, 1'b1, 2'd1, 3'd2, 16'h0000, 3'd2, 3'd2, 8'h5B, 8'h5B, 8'h5B};
    vec[10] = '{1'b1, 1'b1, 2'd3, 3'd1, 16'h00AA, 3'd1, 3'd2, 8'h00, 8'h5B, 8'h00};
    vec[11] = '{1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd1, 3'd0, 8'h00, 8'h00, 8'h00};
    vec[12] = '{1'b1, 1'b1, 2'd0, 3'd0, 16'h0077, 3'd0, 3'd0, 8'h77, 8'h77, 8'h77};
    vec[13] = '{1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd0, 3'd3, 8'h77, 8'hFF, 8'h00};

    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      apply(vec[i].rst_n, vec[i].wen, vec[i].op, vec[i].wa, vec[i].wd, vec[i].ra, vec[i].rb);
      $display("txn vec%0d op=%0d wa=%0d rdata_a=%h rdata_b=%h wval=%h",
               i, vec[i].op, vec[i].wa, a0, b0, w0);
      chk($sformatf("vec%0d rdata_a", i), {8'h00, a0}, {8'h00, vec[i].ea});
      chk($sformatf("vec%0d rdata_b", i), {8'h00, b0}, {8'h00, vec[i].eb});
      chk($sformatf("vec%0d wval", i),    {8'h00, w0}, {8'h00, vec[i].ew});
      check_all($sformatf("vec%0d", i));
      commit();
    end

    // No-bypass instance: INC shows the old value until the edge.
    step("nb_load", 1'b1, 1'b1, 2'd0, 3'd2, 16'h005A, 3'd2, 3'd2);
    apply(1'b1, 1'b1, 2'd1, 3'd2, 16'h0000, 3'd2, 3'd2);
    $display("txn nb_inc bypass=%h nobypass=%h", a0, a1);
    chk("nb pre-edge no bypass", got_a[1], 16'h005A);
    chk("nb pre-edge bypass", got_a[0], 16'h005B);
    check_all("nb_inc");
    commit();
    step("nb_after", 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd2, 3'd2);
    chk("nb post-edge", got_a[1], 16'h005B);

    // Zero register: write to reg0 discarded on the ZERO_REG instance.
    apply(1'b1, 1'b1, 2'd0, 3'd0, 16'h0077, 3'd0, 3'd0);
    $display("txn zr_load zr_rd=%h zr_wval=%h plain_rd=%h", a2, w2, a0);
    chk("zr pre-edge read", got_a[2], 16'h0000);
    chk("zr wval", got_w[2], 16'h0000);
    chk("zr plain bypass", got_a[0], 16'h0077);
    check_all("zr_load");
    commit();
    step("zr_after", 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd0, 3'd0);
    chk("zr post-edge read", got_a[2], 16'h0000);
    chk("zr plain post-edge", got_b[0], 16'h0077);

    // Mid-operation reset.
    step("mr_l1", 1'b1, 1'b1, 2'd0, 3'd1, 16'h0011, 3'd1, 3'd2);
    step("mr_l2", 1'b1, 1'b1, 2'd0, 3'd2, 16'h0022, 3'd1, 3'd2);
    step("mr_l3", 1'b1, 1'b1, 2'd0, 3'd3, 16'h0033, 3'd2, 3'd3);
    apply(1'b1, 1'b1, 2'd0, 3'd1, 16'h0099, 3'd1, 3'd3);
    chk("mr bypass before reset", got_a[0], 16'h0099);
    chk("mr reg3 before reset", got_b[0], 16'h0033);
    #2 rst_n = 1'b0;
    #1;
    $display("txn mr_reset rdata_a=%h rdata_b=%h", a0, b0);
    chk("mr reset read a", got_a[0], 16'h0000);
    chk("mr reset read b", got_b[0], 16'h0000);
    check_all("mr_reset");
    commit();
    apply(1'b1, 1'b1, 2'd0, 3'd1, 16'h0099, 3'd1, 3'd3);
    chk("mr released not yet written", got_a[1], 16'h0000);
    check_all("mr_release");
    commit();
    step("mr_after", 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd1, 3'd3);
    chk("mr write after release", got_a[1], 16'h0099);
    chk("mr reg3 cleared", got_b[0], 16'h0000);

    // 16x8 instance: wrap of reg7, independent dual read with reg6.
    step("w16_l6", 1'b1, 1'b1, 2'd0, 3'd6, 16'h1234, 3'd6, 3'd7);
    step("w16_l7", 1'b1, 1'b1, 2'd0, 3'd7, 16'hFFFF, 3'd7, 3'd6);
    apply(1'b1, 1'b1, 2'd1, 3'd7, 16'h0000, 3'd7, 3'd6);
    $display("txn w16_inc rdata_a=%h rdata_b=%h wval=%h", a3, b3, w3);
    chk("w16 inc wrap bypass", got_a[3], 16'h0000);
    chk("w16 reg6 independent", got_b[3], 16'h1234);
    chk("w16 wval", got_w[3], 16'h0000);
    check_all("w16_inc");
    commit();
    step("w16_after", 1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 3'd7, 3'd6);
    chk("w16 reg7 post", got_a[3], 16'h0000);
    chk("w16 reg6 post", got_b[3], 16'h1234);

    // Randomized run against the model.
    for (int i = 0; i < 300; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 39) != 0), 1'($urandom),
           2'($urandom), 3'($urandom), 16'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
Parametrised multi-register storage block, the successor to the single 8-bit write-enabled register. It holds DEPTH registers of WIDTH bits, with one write port supporting load, increment, decrement and clear operations, and two asynchronous read ports with optional write-to-read bypass. It serves as the CPU's general-purpose register bank and as a PC/SP counter store.

Parameters:
WIDTH, 8, data width of every register in bits (>=2)
DEPTH, 4, number of registers; must be a power of two and >=2
ZERO_REG, 0, if 1, register 0 is hardwired to zero
BYPASS, 1, if 1, a same-cycle write is forwarded to a matching read port
(ADDR_W = $clog2(DEPTH) is a derived localparam, not overridable.)

Ports:
clk_i  input  1  clock; all state updates occur on its rising edge
rst_n_i  input  1  asynchronous active-low reset
wen_i  input  1  write enable for the write port
wop_i  input  2  write op: 00 LOAD, 01 INC, 10 DEC, 11 CLR
waddr_i  input  ADDR_W  target register for the write op
wdata_i  input  WIDTH  data for LOAD; ignored for the other ops
raddr_a_i  input  ADDR_W  read port A address
raddr_b_i  input  ADDR_W  read port B address
rdata_a_o  output  WIDTH  read port A data
rdata_b_o  output  WIDTH  read port B data
wval_o  output  WIDTH  value written this cycle (next value of regs[waddr_i]); 0 when wen_i=0

Behaviour:
- Reset: rst_n_i=0 clears all registers to 0 immediately, with no clock required. Reset overrides any write in the same cycle. The read outputs follow the cleared state combinationally, so they read 0 during reset.
- Write, committed on the rising clk_i edge when wen_i=1 and rst_n_i=1:
  - LOAD: regs[waddr] <= wdata_i
  - INC: regs[waddr] <= regs[waddr] + 1, modulo 2^WIDTH (max value wraps to 0)
  - DEC: regs[waddr] <= regs[waddr] - 1, modulo 2^WIDTH (0 wraps to all-ones)
  - CLR: regs[waddr] <= 0
- wen_i=0: no register changes, whatever wop_i holds. Only the addressed register changes; all others hold.
- Next value: wval_o is computed combinationally from the current register value and wop_i, with one-cycle write latency. Reads observe the committed value after the edge.
- Reads: asynchronous, rdata_x_o = regs[raddr_x_i]. Both ports may address the same register or any register independently.
- Bypass (BYPASS=1): when wen_i=1 and raddr_x_i==waddr_i, rdata_x_o = wval_o in the same cycle. This applies to INC/DEC/CLR too, not only LOAD.
- No bypass (BYPASS=0): reads return the pre-edge stored value until the edge.
- ZERO_REG=1:
  - Reads of address 0 return 0 and the bypass does not apply to them.
  - Writes to address 0 are discarded, and wval_o reads 0 for them.
  - Register 0 storage may be optimised away.
- Out-of-range addresses cannot occur, because DEPTH is a power of two.
- Inputs are sampled only at the clock edge; mid-cycle changes to them have no effect on state.

Test Plan:
- Reset and load: assert rst_n_i=0 -> all reads 0. Release reset, LOAD reg1=0xCC -> after the edge, rdata_a_o(raddr=1)=0xCC and the other registers remain 0.
- Write disable: wen_i=0, LOAD reg1 with 0xFF for 2 cycles -> reg1 stays 0xCC. Then INC reg2 from 0xFF -> 0x00; DEC reg3 from 0x00 -> 0xFF.
- Bypass (BYPASS=1): LOAD reg2=0x5A with raddr_a=raddr_b=2 -> both outputs show 0x5A before the edge. INC with reg2=0x5A -> shows 0x5B pre-edge. Rerun with BYPASS=0 -> shows 0x5A until the edge.
- Zero register (ZERO_REG=1): LOAD reg0=0x77 -> reg0 reads 0 before and after the edge, and wval_o=0. Same test with ZERO_REG=0 -> reg0 reads 0x77.
- Mid-operation reset: load reg1..reg3 with 0x11/0x22/0x33, then pull rst_n_i low between edges while wen_i=1 -> all reads are 0 immediately, before any edge. On release the write does not occur until the next edge.
- Parametric run: WIDTH=16, DEPTH=8. LOAD reg7=0xFFFF, then INC -> 0x0000. Dual-port read of reg7 and reg6 returns independent values.
